// File: rtl/counter_pkg.sv
// Shared definitions for the programmable modulus counter family.
// Holds the direction encodings, the wrap-counter limits and the helper
// that turns a modulus into its terminal (last) count value.
package counter_pkg;

  // Direction encodings for the 'up' input
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Width and saturation value of the optional wrap event counter
  localparam int         WRAP_CNT_W   = 8;
  localparam logic [7:0] WRAP_CNT_MAX = 8'hFF;

  // Last count value for a modulus m at a given width.
  // A modulus of 0 stands for 2^width, so m-1 wraps to all ones,
  // which is exactly the full-range terminal value.
  function automatic logic [31:0] terminal_of(input logic [31:0] m,
                                              input int unsigned width);
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (m - 32'd1) & mask;
  endfunction

endpackage

// File: rtl/prog_mod_counter_shadow.sv
// mod_shadow_reg: double-buffered modulus storage for prog_mod_counter.
// A written modulus sits in the shadow register until the counter wraps
// or loads; only then does it become the active modulus.
module mod_shadow_reg #(
  parameter int N         = 4,
  parameter int M_DEFAULT = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         m_wr,
  input  logic [N-1:0] m_in,
  input  logic         apply,
  output logic [N-1:0] m_new,
  output logic [N-1:0] m_cur,
  output logic         m_pend
);

  localparam logic [N-1:0] M_RESET = N'(M_DEFAULT);

  logic [N-1:0] m_shad;
  logic [N-1:0] m_act;
  logic         pend_q;

  // Modulus that takes effect at the next wrap/load: a write in the same
  // cycle goes straight through, otherwise a pending write, else unchanged
  always_comb begin
    m_new = m_act;
    if (m_wr && apply) begin
      m_new = m_in;
    end else if (pend_q) begin
      m_new = m_shad;
    end
  end

  // Shadow/active modulus registers; a wrap or load retires any pending write
  always_ff @(posedge clk) begin
    if (reset) begin
      m_shad <= M_RESET;
      m_act  <= M_RESET;
      pend_q <= 1'b0;
    end else if (apply) begin
      m_act  <= m_new;
      m_shad <= m_new;
      pend_q <= 1'b0;
    end else if (m_wr) begin
      m_shad <= m_in;
      pend_q <= 1'b1;
    end
  end

  assign m_cur  = m_act;
  assign m_pend = pend_q;

endmodule

// File: rtl/prog_mod_counter.sv
// prog_mod_counter: up/down mod-M counter with run-time programmable,
// double-buffered modulus, parallel load and a zero-latency terminal tick.
// Optional feature macro: PMC_WRAP_CNT_EN adds an 8-bit saturating count of
// terminal ticks (wrap_cnt) with a synchronous clear (wrap_clr).
module prog_mod_counter
  import counter_pkg::*;
#(
  parameter int N         = 4,
  parameter int M_DEFAULT = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [N-1:0] d,
  input  logic         m_wr,
  input  logic [N-1:0] m_in,
`ifdef PMC_WRAP_CNT_EN
  input  logic         wrap_clr,
  output logic [WRAP_CNT_W-1:0] wrap_cnt,
`endif
  output logic [N-1:0] q,
  output logic         max_tick,
  output logic         m_pend,
  output logic [N-1:0] m_cur
);

  logic [N-1:0] m_new;
  logic [N-1:0] term_up;
  logic [N-1:0] new_last;
  logic [N-1:0] load_val;
  logic [N-1:0] q_next;
  logic         terminal;
  logic         wrap;
  logic         apply;

  mod_shadow_reg #(
    .N         (N),
    .M_DEFAULT (M_DEFAULT)
  ) u_shadow (
    .clk    (clk),
    .reset  (reset),
    .m_wr   (m_wr),
    .m_in   (m_in),
    .apply  (apply),
    .m_new  (m_new),
    .m_cur  (m_cur),
    .m_pend (m_pend)
  );

  assign term_up  = N'(terminal_of(32'(m_cur), N));
  assign new_last = N'(terminal_of(32'(m_new), N));

  // Terminal detection for the current direction and the tick/apply strobes;
  // a load overrides counting, so only an unloaded terminal cycle is a wrap
  always_comb begin
    terminal = (up == DIR_UP) ? (q == term_up) : (q == '0);
    max_tick = en & terminal;
    wrap     = max_tick & ~load;
    apply    = wrap | load;
  end

  // Load value clamped into the range of the modulus it will run under
  always_comb begin
    load_val = d;
    if ((m_new != '0) && (d >= m_new)) begin
      load_val = new_last;
    end
  end

  // Next count: load beats counting; down-wraps land on the new modulus top
  always_comb begin
    q_next = q;
    if (load) begin
      q_next = load_val;
    end else if (en) begin
      if (up == DIR_UP) begin
        q_next = terminal ? '0 : q + 1'b1;
      end else begin
        q_next = terminal ? new_last : q - 1'b1;
      end
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else begin
      q <= q_next;
    end
  end

`ifdef PMC_WRAP_CNT_EN
  // Saturating tally of terminal ticks; clear wins over increment
  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_cnt <= '0;
    end else if (wrap_clr) begin
      wrap_cnt <= '0;
    end else if (max_tick && (wrap_cnt != WRAP_CNT_MAX)) begin
      wrap_cnt <= wrap_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_prog_mod_counter.sv
// Testbench for prog_mod_counter (N=4, M_DEFAULT=10).
// Directed scenarios followed by random stimulus, all compared against an
// integer-arithmetic model of the counter kept in this file.
module tb_prog_mod_counter;

  localparam int N         = 4;
  localparam int M_DEFAULT = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         up;
  logic         load;
  logic [N-1:0] d;
  logic         m_wr;
  logic [N-1:0] m_in;
  logic         wrapClr;
  logic [N-1:0] q;
  logic         maxTick;
  logic         mPend;
  logic [N-1:0] mCur;
`ifdef PMC_WRAP_CNT_EN
  logic [7:0]   wrapCnt;
`endif

  int checks   = 0;
  int failures = 0;

  // Model state: moduli held as integers 1..16 (16 = full range)
  int modQ;
  int modAct;
  int modShad;
  bit modPend;
  int modWrap;
  bit lastTick;

  prog_mod_counter #(.N(N), .M_DEFAULT(M_DEFAULT)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .load     (load),
    .d        (d),
    .m_wr     (m_wr),
    .m_in     (m_in),
`ifdef PMC_WRAP_CNT_EN
    .wrap_clr (wrapClr),
    .wrap_cnt (wrapCnt),
`endif
    .q        (q),
    .max_tick (maxTick),
    .m_pend   (mPend),
    .m_cur    (mCur)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  function automatic int decodeMod(input logic [N-1:0] m);
    return (m == 0) ? (1 << N) : int'(m);
  endfunction

  // Drive one cycle of inputs, check the tick, clock, then check the state
  task automatic applyStimulus(input logic r, input logic e, input logic u,
                               input logic l, input logic [N-1:0] dv,
                               input logic w, input logic [N-1:0] mi,
                               input logic wc);
    bit term;
    bit tickExp;
    bit apply;
    int mNew;
    @(negedge clk);
    reset = r; en = e; up = u; load = l; d = dv; m_wr = w; m_in = mi; wrapClr = wc;
    term    = u ? (modQ == modAct - 1) : (modQ == 0);
    tickExp = e && term;
    #1;
    lastTick = maxTick;
    if (!r && !l) checkOutput("max_tick", 32'(maxTick), 32'(tickExp));
    @(posedge clk);
    if (r) begin
      modQ = 0; modAct = M_DEFAULT; modShad = M_DEFAULT; modPend = 0; modWrap = 0;
    end else begin
      apply = (tickExp && !l) || l;
      mNew  = (w && apply) ? decodeMod(mi) : (modPend ? modShad : modAct);
      if (wc) modWrap = 0;
      else if (tickExp && modWrap < 255) modWrap++;
      if (l) modQ = (int'(dv) >= mNew) ? mNew - 1 : int'(dv);
      else if (e) begin
        if (u) modQ = term ? 0 : modQ + 1;
        else   modQ = term ? mNew - 1 : modQ - 1;
      end
      if (apply) begin
        modAct = mNew; modShad = mNew; modPend = 0;
      end else if (w) begin
        modShad = decodeMod(mi); modPend = 1;
      end
    end
    #1;
    checkOutput("q", 32'(q), 32'(modQ));
    checkOutput("m_cur", 32'(mCur), 32'(modAct % (1 << N)));
    checkOutput("m_pend", 32'(mPend), 32'(modPend));
`ifdef PMC_WRAP_CNT_EN
    checkOutput("wrap_cnt", 32'(wrapCnt), 32'(modWrap));
`endif
  endtask

  initial begin
    int tickSeen;
    reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; d = '0;
    m_wr = 1'b0; m_in = '0; wrapClr = 1'b0;
    modQ = 0; modAct = M_DEFAULT; modShad = M_DEFAULT; modPend = 0; modWrap = 0;

    // Reset state
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 1, 4'd3, 0);
    checkOutput("reset_q", 32'(q), 32'd0);
    checkOutput("reset_m_cur", 32'(mCur), 32'd10);
    #1;
    en = 1'b0;
    #1;
    checkOutput("reset_tick", 32'(maxTick), 32'd0);

    // Up count for 25 cycles: two ticks
    tickSeen = 0;
    for (int i = 0; i < 25; i++) begin
      applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
      if (lastTick) tickSeen++;
    end
    checkOutput("up_tick_pulses", 32'(tickSeen), 32'd2);

    // Direction flip at q=5, then down count through a wrap to 9
    checkOutput("flip_start_q", 32'(q), 32'd5);
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("down_wrap_q", 32'(q), 32'd7);

    // Modulus write at q=3 stays pending until the wrap
    applyStimulus(0, 0, 1, 1, 4'd3, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 1, 4'd5, 0);
    for (int i = 0; i < 12; i++) applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
    checkOutput("new_mod_active", 32'(mCur), 32'd5);

    // Write coincident with a down wrap applies immediately
    applyStimulus(0, 0, 1, 1, 4'd0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 1, 4'd6, 0);
    checkOutput("coincident_q", 32'(q), 32'd5);

    // Load clamp with m=10, then load beating enable
    applyStimulus(0, 0, 1, 1, 4'd12, 1, 4'd10, 0);
    checkOutput("load_clamp", 32'(q), 32'd9);
    applyStimulus(0, 1, 1, 1, 4'd2, 0, 0, 0);
    checkOutput("load_wins", 32'(q), 32'd2);

    // Reset discards a pending modulus
    applyStimulus(0, 1, 1, 0, 0, 1, 4'd7, 0);
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 0);
    checkOutput("reset_pend", 32'(mPend), 32'd0);

    // Full range modulus: wrap 15 -> 0 with tick
    applyStimulus(0, 0, 1, 1, 4'd14, 1, 4'd0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
    checkOutput("full_range_q", 32'(q), 32'd2);

    // Modulus 1: q stays 0, tick every cycle both directions
    applyStimulus(0, 0, 1, 1, 4'd5, 1, 4'd1, 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, i[0], 0, 0, 0, 0, 0);

`ifdef PMC_WRAP_CNT_EN
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 300; i++) applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
    checkOutput("wrap_sat", 32'(wrapCnt), 32'd255);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 1);
    checkOutput("wrap_clr", 32'(wrapCnt), 32'd0);
`endif

    // Random stimulus against the model
    for (int i = 0; i < 500; i++) begin
      applyStimulus($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
                    1'($urandom), $urandom_range(0, 11) == 0, 4'($urandom),
                    $urandom_range(0, 9) == 0, 4'($urandom),
                    $urandom_range(0, 31) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
